// File: rtl/touch_adc_responder_if.sv
// Serial link between the touchpad controller (master) and the touch ADC model (slave).
interface touch_adc_responder_if;
  logic touch_clk;
  logic touch_csb;
  logic data_out;
  logic data_in;
  logic touch_busy;

  modport master (
    output touch_clk,
    output touch_csb,
    output data_out,
    input  data_in,
    input  touch_busy
  );

  modport slave (
    input  touch_clk,
    input  touch_csb,
    input  data_out,
    output data_in,
    output touch_busy
  );
endinterface

// File: rtl/touch_adc_responder.sv
// Touch-screen ADC model: takes an 8-bit command frame, holds busy for BUSY_EDGES
// touch_clk rises, then returns a DATA_W-bit X/Y/Z value MSB first.
module touch_adc_responder #(
  parameter int BUSY_EDGES = 1,
  parameter int DATA_W     = 12
) (
  input  logic                 cclk,
  input  logic                 rstb,
  touch_adc_responder_if.slave link,
  input  logic [DATA_W-1:0]    x_value,
  input  logic [DATA_W-1:0]    y_value,
  input  logic [DATA_W-1:0]    z_value,
  output logic [7:0]           last_cmd,
  output logic                 conv_done
);

  localparam int              BW        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [3:0]      BUSY_LAST = 4'(BUSY_EDGES);
  localparam logic [BW-1:0]   BITS_INIT = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CMD, BUSY, SHIFT} state_t;

  state_t            state, state_n;

  logic              tclk_p0, tclk_p1, tclk_p2;
  logic              csb_p0, csb_p1;
  logic              dout_p0, dout_p1;
  logic              rise, fall;

  logic [6:0]        cmd_sr, cmd_sr_n;
  logic [7:0]        cmd_next;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [3:0]        edge_cnt, edge_cnt_n;
  logic [DATA_W-1:0] result_sr, result_sr_n;
  logic [BW-1:0]     bits_left, bits_left_n;
  logic              data_in_q, data_in_n;
  logic              busy_q, busy_n;
  logic [7:0]        last_cmd_n;
  logic              conv_done_n;

  function automatic logic [DATA_W-1:0] select_value(
    input logic [2:0]        addr,
    input logic [DATA_W-1:0] xv,
    input logic [DATA_W-1:0] yv,
    input logic [DATA_W-1:0] zv
  );
    case (addr)
      3'b101:  return xv;
      3'b001:  return yv;
      3'b011:  return zv;
      default: return '0;
    endcase
  endfunction

  // Two-flop synchronisers; tclk_p2 is the previous synchronised sample for edge detection
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      tclk_p0 <= 1'b0;
      tclk_p1 <= 1'b0;
      tclk_p2 <= 1'b0;
      csb_p0  <= 1'b0;
      csb_p1  <= 1'b0;
      dout_p0 <= 1'b0;
      dout_p1 <= 1'b0;
    end else begin
      tclk_p0 <= link.touch_clk;
      tclk_p1 <= tclk_p0;
      tclk_p2 <= tclk_p1;
      csb_p0  <= link.touch_csb;
      csb_p1  <= csb_p0;
      dout_p0 <= link.data_out;
      dout_p1 <= dout_p0;
    end
  end

  assign rise     = tclk_p1 & ~tclk_p2;
  assign fall     = ~tclk_p1 & tclk_p2;
  assign cmd_next = {cmd_sr, dout_p1};

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (csb_p1) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise && dout_p1)                  state_n = CMD;
        CMD:     if (rise && bit_cnt == 3'd7)          state_n = BUSY;
        BUSY:    if (fall && edge_cnt == BUSY_LAST)    state_n = SHIFT;
        SHIFT:   if (fall && bits_left == '0)          state_n = IDLE;
        default:                                       state_n = IDLE;
      endcase
    end
  end

  // Serial outputs only move on a touch_clk fall so the controller's rise sample is stable
  always_comb begin
    cmd_sr_n    = cmd_sr;
    bit_cnt_n   = bit_cnt;
    edge_cnt_n  = edge_cnt;
    result_sr_n = result_sr;
    bits_left_n = bits_left;
    data_in_n   = data_in_q;
    busy_n      = busy_q;
    last_cmd_n  = last_cmd;
    conv_done_n = 1'b0;
    if (csb_p1) begin
      bit_cnt_n   = '0;
      edge_cnt_n  = '0;
      bits_left_n = '0;
      data_in_n   = 1'b0;
      busy_n      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise && dout_p1) begin
            cmd_sr_n  = 7'h01;
            bit_cnt_n = 3'd1;
          end
        end
        CMD: begin
          if (rise) begin
            cmd_sr_n  = cmd_next[6:0];
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              last_cmd_n  = cmd_next;
              result_sr_n = select_value(cmd_next[6:4], x_value, y_value, z_value);
              edge_cnt_n  = '0;
            end
          end
        end
        BUSY: begin
          if (rise && edge_cnt != BUSY_LAST) edge_cnt_n = edge_cnt + 4'd1;
          if (fall) begin
            if (edge_cnt == BUSY_LAST) begin
              busy_n      = 1'b0;
              data_in_n   = result_sr[DATA_W-1];
              bits_left_n = BITS_INIT;
            end else begin
              busy_n      = 1'b1;
            end
          end
        end
        SHIFT: begin
          if (fall) begin
            if (bits_left != '0) begin
              result_sr_n = result_sr << 1;
              data_in_n   = result_sr[DATA_W-2];
              bits_left_n = bits_left - BW'(1);
            end else begin
              data_in_n   = 1'b0;
              conv_done_n = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      cmd_sr    <= '0;
      bit_cnt   <= '0;
      edge_cnt  <= '0;
      result_sr <= '0;
      bits_left <= '0;
      data_in_q <= 1'b0;
      busy_q    <= 1'b0;
      last_cmd  <= '0;
      conv_done <= 1'b0;
    end else begin
      cmd_sr    <= cmd_sr_n;
      bit_cnt   <= bit_cnt_n;
      edge_cnt  <= edge_cnt_n;
      result_sr <= result_sr_n;
      bits_left <= bits_left_n;
      data_in_q <= data_in_n;
      busy_q    <= busy_n;
      last_cmd  <= last_cmd_n;
      conv_done <= conv_done_n;
    end
  end

  assign link.data_in    = data_in_q;
  assign link.touch_busy = busy_q;

endmodule

// File: tb/tb_touch_adc_responder.sv
// Bench for touch_adc_responder: two instances (BUSY_EDGES 1 and 3) share one
// controller-style stimulus; a monitor decodes each returned frame against a queue.
module tb_touch_adc_responder;
  localparam int DATA_W = 12;

  typedef struct packed {
    logic [7:0]        cmd;
    logic [DATA_W-1:0] val;
  } exp_t;

  logic              cclk = 1'b0;
  logic              rstb = 1'b0;
  logic              tclk = 1'b0;
  logic              csb  = 1'b1;
  logic              dout = 1'b0;
  logic [DATA_W-1:0] xv = '0, yv = '0, zv = '0;
  logic [7:0]        lc1, lc3;
  logic              done1, done3;

  int nvec = 0;
  int nmis = 0;
  int dcnt1 = 0, dcnt3 = 0;

  exp_t q1[$];
  exp_t q3[$];

  touch_adc_responder_if l1();
  touch_adc_responder_if l3();

  assign l1.touch_clk = tclk;
  assign l1.touch_csb = csb;
  assign l1.data_out  = dout;
  assign l3.touch_clk = tclk;
  assign l3.touch_csb = csb;
  assign l3.data_out  = dout;

  touch_adc_responder #(.BUSY_EDGES(1), .DATA_W(DATA_W)) dut1 (
    .cclk(cclk), .rstb(rstb), .link(l1),
    .x_value(xv), .y_value(yv), .z_value(zv),
    .last_cmd(lc1), .conv_done(done1)
  );

  touch_adc_responder #(.BUSY_EDGES(3), .DATA_W(DATA_W)) dut3 (
    .cclk(cclk), .rstb(rstb), .link(l3),
    .x_value(xv), .y_value(yv), .z_value(zv),
    .last_cmd(lc3), .conv_done(done3)
  );

  always #5 cclk = ~cclk;

  always @(negedge cclk) begin
    if (done1 === 1'b1) dcnt1++;
    if (done3 === 1'b1) dcnt3++;
  end

  task automatic check(input string name, input int lane,
                       input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s (busy_edges=%0d): got %0h, expected %0h", name, lane, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic din_e, input logic busy_e,
                            input logic [7:0] lc_e);
    check({tag, "_data_in"},    1, 32'(l1.data_in),    32'(din_e));
    check({tag, "_busy"},       1, 32'(l1.touch_busy), 32'(busy_e));
    check({tag, "_last_cmd"},   1, 32'(lc1),           32'(lc_e));
    check({tag, "_conv_done"},  1, 32'(done1),         32'd0);
    check({tag, "_data_in"},    3, 32'(l3.data_in),    32'(din_e));
    check({tag, "_busy"},       3, 32'(l3.touch_busy), 32'(busy_e));
    check({tag, "_last_cmd"},   3, 32'(lc3),           32'(lc_e));
    check({tag, "_conv_done"},  3, 32'(done3),         32'd0);
  endtask

  // Monitor: per lane, count busy rises, collect DATA_W bits, then check the trailing rise
  int                phase [2];
  int                bcnt  [2];
  int                nbits [2];
  int                frames[2];
  logic [DATA_W-1:0] mbits [2];
  exp_t              rec;
  logic              m_din, m_busy;
  logic [7:0]        m_lc;
  int                m_dcnt, m_lane;
  logic              m_have;

  initial begin
    for (int l = 0; l < 2; l++) begin
      phase[l] = 0; bcnt[l] = 0; nbits[l] = 0; frames[l] = 0; mbits[l] = '0;
    end
  end

  always @(posedge tclk or negedge rstb or posedge csb) begin
    if (!rstb || csb) begin
      for (int l = 0; l < 2; l++) phase[l] = 0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        m_din  = (l == 0) ? l1.data_in    : l3.data_in;
        m_busy = (l == 0) ? l1.touch_busy : l3.touch_busy;
        m_lc   = (l == 0) ? lc1           : lc3;
        m_dcnt = (l == 0) ? dcnt1         : dcnt3;
        m_lane = (l == 0) ? 1             : 3;
        case (phase[l])
          0: if (m_busy) begin phase[l] = 1; bcnt[l] = 1; end
          1: begin
            if (m_busy) bcnt[l]++;
            else begin
              mbits[l] = DATA_W'(m_din);
              nbits[l] = 1;
              phase[l] = 2;
            end
          end
          2: begin
            mbits[l] = {mbits[l][DATA_W-2:0], m_din};
            nbits[l]++;
            if (nbits[l] == DATA_W) phase[l] = 3;
          end
          default: begin
            frames[l]++;
            m_have = 1'b0;
            if (l == 0 && q1.size() > 0) begin rec = q1.pop_front(); m_have = 1'b1; end
            if (l == 1 && q3.size() > 0) begin rec = q3.pop_front(); m_have = 1'b1; end
            if (!m_have) check("unexpected_frame", m_lane, 32'd1, 32'd0);
            else begin
              check("result_bits",   m_lane, 32'(mbits[l]), 32'(rec.val));
              check("busy_rises",    m_lane, 32'(bcnt[l]),  32'(m_lane));
              check("last_cmd",      m_lane, 32'(m_lc),     32'(rec.cmd));
            end
            check("conv_done_cnt", m_lane, 32'(m_dcnt), 32'(frames[l]));
            check("trailing_zero", m_lane, 32'(m_din),  32'd0);
            phase[l] = 0;
          end
        endcase
      end
    end
  end

  task automatic tcycle(input logic b);
    dout = b;
    repeat (5) @(negedge cclk);
    tclk = 1'b1;
    repeat (5) @(negedge cclk);
    tclk = 1'b0;
  endtask

  task automatic start_frame();
    csb = 1'b0;
    repeat (5) @(negedge cclk);
  endtask

  task automatic send_cmd(input logic [7:0] cmd);
    for (int i = 7; i >= 0; i--) tcycle(cmd[i]);
  endtask

  task automatic clocks(input int n);
    for (int i = 0; i < n; i++) tcycle(1'b0);
  endtask

  task automatic stop_frame();
    repeat (5) @(negedge cclk);
    csb = 1'b1;
    repeat (8) @(negedge cclk);
  endtask

  task automatic expect_frame(input logic [7:0] cmd, input logic [DATA_W-1:0] val);
    q1.push_back('{cmd: cmd, val: val});
    q3.push_back('{cmd: cmd, val: val});
  endtask

  task automatic full_frame(input logic [7:0] cmd, input logic [DATA_W-1:0] val);
    expect_frame(cmd, val);
    start_frame();
    send_cmd(cmd);
    clocks(18);
    stop_frame();
  endtask

  initial begin
    repeat (3) @(posedge cclk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 8'h00);
    @(negedge cclk) rstb = 1'b1;
    repeat (5) @(negedge cclk);

    xv = 12'hA5C; yv = 12'h12C; zv = 12'hFFF;
    full_frame(8'hD3, 12'hA5C);

    // Y frame: change y_value after the command to confirm the snapshot holds
    expect_frame(8'h93, 12'h12C);
    start_frame();
    send_cmd(8'h93);
    yv = 12'h000;
    clocks(18);
    stop_frame();

    full_frame(8'hB3, 12'hFFF);
    full_frame(8'hE3, 12'h000);

    // Abort after five command bits
    start_frame();
    for (int i = 7; i >= 3; i--) tcycle(8'h93 >> i);
    @(negedge cclk) csb = 1'b1;
    repeat (3) @(posedge cclk);
    #1;
    check_outs("abort", 1'b0, 1'b0, 8'hE3);
    repeat (8) @(negedge cclk);
    xv = 12'h096;
    full_frame(8'hD3, 12'h096);

    // Reset while both instances are shifting out an all-ones result
    zv = 12'hFFF;
    start_frame();
    send_cmd(8'hB3);
    clocks(7);
    repeat (4) @(negedge cclk);
    check("pre_reset_data_in", 1, 32'(l1.data_in), 32'd1);
    check("pre_reset_data_in", 3, 32'(l3.data_in), 32'd1);
    rstb = 1'b0;
    #1;
    check_outs("mid_reset", 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge cclk);
    csb = 1'b1;
    repeat (3) @(negedge cclk);
    rstb = 1'b1;
    repeat (5) @(negedge cclk);

    yv = 12'h123;
    full_frame(8'h93, 12'h123);

    repeat (20) @(negedge cclk);
    check("queue_drain", 1, 32'(q1.size()), 32'd0);
    check("queue_drain", 3, 32'(q3.size()), 32'd0);
    check("frames_seen", 1, 32'(frames[0]), 32'd6);
    check("frames_seen", 3, 32'(frames[1]), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/touch_adc_responder.md
Name: touch_adc_responder

Overview:
- Synthesizable model of the touch-screen ADC that sits on the far side of the touchpad controller's serial link.
- Receives the 8-bit command frame, asserts busy for a programmable time, then shifts out a 12-bit conversion result MSB first.
- Used in the synthesis rig and benches to drive the touchpad controller with known X/Y/Z values, with no real panel attached.

Parameters:
- BUSY_EDGES, 1: number of touch_clk rising edges during which touch_busy is held high after a command (range 1..15).
- DATA_W, 12: conversion result width; the result is shifted out MSB first.

Ports:
- cclk  in  1  system clock; all logic is synchronous to its rising edge.
- rstb  in  1  asynchronous, active-low reset.
- touch_clk  in  1  serial clock from the controller; asynchronous to cclk logic, so it is synchronised.
- touch_csb  in  1  chip select from the controller, active low; synchronised.
- data_out  in  1  command bit stream from the controller; synchronised.
- data_in  out  1  result bit stream to the controller.
- touch_busy  out  1  conversion-in-progress flag to the controller.
- x_value  in  DATA_W  value returned for an X command.
- y_value  in  DATA_W  value returned for a Y command.
- z_value  in  DATA_W  value returned for a Z command.
- last_cmd  out  8  last complete command byte received; bit 7 holds the start bit.
- conv_done  out  1  one-cclk pulse after the last result bit is driven.

Behaviour:
- Reset: rstb low asynchronously clears all state.
  - data_in=0, touch_busy=0, last_cmd=0, conv_done=0.
  - FSM returns to IDLE; all counters and the shift register are cleared.
- Input synchronisation:
  - touch_clk, touch_csb and data_out each pass through a 2-flop synchroniser.
  - Edges are detected on the synchronised touch_clk: rise = sync high and previous sample low; fall = the opposite.
- Bit timing:
  - Command bits are sampled on rise.
  - data_in and touch_busy change only on fall.
  - Exception: abort and reset return these outputs to 0 immediately.
- Chip select: synchronised touch_csb high forces IDLE, data_in=0 and touch_busy=0 on the next cclk, whatever the current state.
- FSM states: IDLE, CMD, BUSY, SHIFT.
- IDLE:
  - On rise with data_out=1 (start bit): shift 1 into cmd_sr, set bit_cnt=1, go to CMD.
  - On rise with data_out=0: stay in IDLE.
- CMD:
  - Each rise shifts data_out into cmd_sr (first bit received ends at bit 7) and increments bit_cnt.
  - On the rise that captures the 8th bit: load last_cmd, then decode address A2..A0 = cmd bits 6..4.
    - 3'b101 selects x_value.
    - 3'b001 selects y_value.
    - 3'b011 selects z_value.
    - Any other code selects 0.
  - The selected value is snapshotted into result_sr in that same cycle; later input changes do not affect the frame. Then go to BUSY.
- BUSY:
  - On the first fall after entry, touch_busy=1.
  - Count rises; once BUSY_EDGES rises have occurred, the next fall sets touch_busy=0, drives data_in = result_sr MSB, and moves to SHIFT with bits_left = DATA_W-1.
- SHIFT:
  - Each fall shifts result_sr left and drives the new MSB while bits_left>0, decrementing bits_left.
  - On the fall where bits_left==0: data_in=0, conv_done pulses for one cclk, go to IDLE.
  - data_out is ignored during BUSY and SHIFT.
- Simultaneous events:
  - csb-high abort takes priority over any edge in the same cycle.
  - A start bit cannot be detected on the same fall that ends SHIFT; IDLE waits for the next rise.
- Abort mid-frame: last_cmd and result_sr are not updated by a partial frame. conv_done does not pulse.
- Reset mid-frame: immediate return to the reset values. The next frame requires a fresh start bit.
- Output stability: data_in is stable for a full touch_clk high phase, so the controller's rising-edge sample is always valid for half-periods of at least 4 cclk.

Test Plan:
- X frame: controller-style stream 1,1,0,1,0,0,1,1 with x_value=12'hA5C, BUSY_EDGES=1.
  - Required: last_cmd=8'hD3.
  - touch_busy high for exactly one rising edge.
  - data_in on subsequent rises reads 1010_0101_1100, then 0.
  - conv_done pulses once.
- Round robin X, Y, Z with x=12'h096, y=12'h12C, z=12'hFFF against the real touchpad controller.
  - Required: controller x_raw, y_raw and z_raw match the driven values after each fourth channel pass.
- Unknown address: command 8'hE3 (A=110).
  - Required: 12 zero bits returned; last_cmd=8'hE3.
- BUSY_EDGES=3.
  - Required: touch_busy spans exactly 3 rises; MSB appears on the fall after the 3rd rise.
- Abort: touch_csb raised after 5 command bits.
  - Required: data_in=0 and touch_busy=0 within 3 cclk; last_cmd unchanged.
  - Required: the next full frame decodes correctly.
- Reset mid-SHIFT: rstb pulsed low after 6 result bits.
  - Required: all outputs 0 immediately; no conv_done pulse.
  - Required: a following Y frame with y_value=12'h123 returns 0001_0010_0011.
